// File: rtl/aes_ui_pkg.sv
// rtl/aes_ui_pkg.sv - shared states, display selects and phase LED codes for the AES UI sequencer
package aes_ui_pkg;

    typedef enum logic [2:0] {
        LD_PT,
        LD_KEY,
        START,
        WAIT,
        SHOW,
        ERR
    } state_t;

    localparam logic [1:0] DSEL_PT  = 2'd0;
    localparam logic [1:0] DSEL_KEY = 2'd1;
    localparam logic [1:0] DSEL_CT  = 2'd2;

    localparam logic [3:0] LED_LD_PT  = 4'b0001;
    localparam logic [3:0] LED_LD_KEY = 4'b0010;
    localparam logic [3:0] LED_RUN    = 4'b0100;
    localparam logic [3:0] LED_SHOW   = 4'b1000;
    localparam logic [3:0] LED_ERR    = 4'b1111;

    function automatic logic [3:0] led_of(input state_t s);
        case (s)
            LD_PT:       led_of = LED_LD_PT;
            LD_KEY:      led_of = LED_LD_KEY;
            START, WAIT: led_of = LED_RUN;
            SHOW:        led_of = LED_SHOW;
            ERR:         led_of = LED_ERR;
            default:     led_of = LED_LD_PT;
        endcase
    endfunction

    // Up-button rotation order CT -> PT -> KEY -> CT; the unused code falls back to PT.
    function automatic logic [1:0] dsel_next(input logic [1:0] s);
        case (s)
            DSEL_CT:  dsel_next = DSEL_PT;
            DSEL_PT:  dsel_next = DSEL_KEY;
            DSEL_KEY: dsel_next = DSEL_CT;
            default:  dsel_next = DSEL_PT;
        endcase
    endfunction

endpackage

// File: rtl/aes_ui_sequencer_release_detect.sv
// rtl/aes_ui_sequencer_release_detect.sv - falling-edge (button release) detector
module release_detect (
    input  logic clkin,
    input  logic rstn,
    input  logic in,
    output logic rel
);

    logic in_q;

    // Cleared on reset so a button held through reset never yields a release.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) in_q <= 1'b0;
        else       in_q <= in;
    end

    assign rel = in_q & ~in;

endmodule

// File: rtl/aes_ui_sequencer.sv
// rtl/aes_ui_sequencer.sv - button-driven capture/launch/display sequencer for the 16-bit AES core
module aes_ui_sequencer
    import aes_ui_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clkin,
    input  logic        rstn,
    input  logic        btn_c,
    input  logic        btn_u,
    input  logic [15:0] sw,
    input  logic        aes_done,
    input  logic [15:0] aes_ct,
    output logic        aes_start,
    output logic [15:0] pt_out,
    output logic [15:0] key_out,
    output logic [15:0] disp_data,
    output logic [1:0]  disp_sel,
    output logic [3:0]  state_led,
    output logic        busy,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_t        state, state_d;
    logic [15:0]   ct_reg, ct_d, pt_d, key_d;
    logic [1:0]    sel_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          rel_c, rel_u;

    release_detect u_rel_c (.clkin(clkin), .rstn(rstn), .in(btn_c), .rel(rel_c));
    release_detect u_rel_u (.clkin(clkin), .rstn(rstn), .in(btn_u), .rel(rel_u));

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state     <= LD_PT;
            pt_out    <= '0;
            key_out   <= '0;
            ct_reg    <= '0;
            disp_sel  <= DSEL_PT;
            cnt       <= '0;
            aes_start <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            state_led <= LED_LD_PT;
        end else begin
            state     <= state_d;
            pt_out    <= pt_d;
            key_out   <= key_d;
            ct_reg    <= ct_d;
            disp_sel  <= sel_d;
            cnt       <= cnt_d;
            // Status outputs are registered from the next state so they align with it.
            aes_start <= (state_d == START);
            busy      <= (state_d == START) || (state_d == WAIT);
            err       <= (state_d == ERR);
            state_led <= led_of(state_d);
        end
    end

    always_comb begin
        state_d = state;
        pt_d    = pt_out;
        key_d   = key_out;
        ct_d    = ct_reg;
        sel_d   = disp_sel;
        cnt_d   = cnt;
        case (state)
            LD_PT: if (rel_c) begin
                pt_d    = sw;
                state_d = LD_KEY;
            end
            LD_KEY: if (rel_c) begin
                key_d   = sw;
                state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt != CNT_MAX) cnt_d = cnt + 1'b1;
                // Completion takes priority over a timeout in the same cycle.
                if (aes_done) begin
                    ct_d    = aes_ct;
                    sel_d   = DSEL_CT;
                    state_d = SHOW;
                end else if (cnt == CNT_MAX) begin
                    state_d = ERR;
                end
            end
            SHOW: begin
                if (rel_c) begin
                    sel_d   = DSEL_PT;
                    state_d = LD_PT;
                end else if (rel_u) begin
                    sel_d = dsel_next(disp_sel);
                end
            end
            ERR: if (rel_c) begin
                sel_d   = DSEL_PT;
                state_d = LD_PT;
            end
            default: state_d = LD_PT;
        endcase
    end

    always_comb begin
        case (state)
            LD_PT, LD_KEY: disp_data = sw;
            SHOW: begin
                case (disp_sel)
                    DSEL_PT:  disp_data = pt_out;
                    DSEL_KEY: disp_data = key_out;
                    default:  disp_data = ct_reg;
                endcase
            end
            default: disp_data = ct_reg;
        endcase
    end

endmodule

// File: tb/tb_aes_ui_sequencer.sv
// tb/tb_aes_ui_sequencer.sv - self-checking bench for aes_ui_sequencer with TIMEOUT=8
module tb_aes_ui_sequencer;

    logic        clkin = 1'b0;
    logic        rstn;
    logic        btn_c, btn_u;
    logic [15:0] sw;
    logic        aes_done;
    logic [15:0] aes_ct;
    logic        aes_start;
    logic [15:0] pt_out, key_out, disp_data;
    logic [1:0]  disp_sel;
    logic [3:0]  state_led;
    logic        busy, err;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: what has been captured and which register is on display.
    logic [15:0] m_pt, m_key, m_ct;
    int          m_sel;

    aes_ui_sequencer #(.TIMEOUT(8)) dut (
        .clkin(clkin), .rstn(rstn), .btn_c(btn_c), .btn_u(btn_u), .sw(sw),
        .aes_done(aes_done), .aes_ct(aes_ct), .aes_start(aes_start),
        .pt_out(pt_out), .key_out(key_out), .disp_data(disp_data),
        .disp_sel(disp_sel), .state_led(state_led), .busy(busy), .err(err)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] shown(input int sel);
        if (sel == 0)      shown = m_pt;
        else if (sel == 1) shown = m_key;
        else               shown = m_ct;
    endfunction

    task automatic release_btn(input logic c, input logic u);
        btn_c = c;
        btn_u = u;
        @(negedge clkin);
        btn_c = 1'b0;
        btn_u = 1'b0;
        @(negedge clkin);
    endtask

    // Captures plaintext and key, then leaves the bench at the negedge of WAIT cycle 0.
    task automatic load_and_start(input logic [15:0] pt, input logic [15:0] key);
        sw = pt;
        release_btn(1'b1, 1'b0);
        m_pt = pt;
        chk("pt_capture", pt_out, m_pt);
        chk("led_ld_key", 16'(state_led), 16'h0002);
        sw = 16'($urandom);
        #1;
        chk("live_sw_ld_key", disp_data, sw);
        sw = key;
        release_btn(1'b1, 1'b0);
        m_key = key;
        chk("start_pulse", 16'(aes_start), 16'h1);
        chk("start_busy", 16'(busy), 16'h1);
        chk("key_capture", key_out, m_key);
        chk("led_start", 16'(state_led), 16'h0004);
        chk("disp_start_ct", disp_data, m_ct);
        sw = 16'($urandom);
        @(negedge clkin);
        chk("start_one_cycle", 16'(aes_start), 16'h0);
        chk("wait_busy0", 16'(busy), 16'h1);
        chk("key_stable", key_out, m_key);
    endtask

    initial begin
        int          dl [4];
        int          n;
        logic [15:0] ct;

        rstn = 1'b0;
        btn_c = 1'b1;
        btn_u = 1'b1;
        aes_done = 1'b0;
        aes_ct = '0;
        sw = 16'($urandom);
        m_pt = '0; m_key = '0; m_ct = '0; m_sel = 0;
        repeat (2) @(negedge clkin);
        chk("rst_led", 16'(state_led), 16'h0001);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_start", 16'(aes_start), 16'h0);
        chk("rst_pt", pt_out, 16'h0);
        chk("rst_key", key_out, 16'h0);
        chk("rst_sel", 16'(disp_sel), 16'h0);
        chk("rst_disp_sw", disp_data, sw);
        rstn = 1'b1;
        btn_c = 1'b0;
        btn_u = 1'b0;
        @(negedge clkin);
        chk("held_through_reset", 16'(state_led), 16'h0001);

        dl[0] = 2; dl[1] = 7; dl[2] = 0; dl[3] = int'($urandom_range(0, 7));
        for (int r = 0; r < 4; r++) begin
            if (r == 0) load_and_start(16'h1234, 16'hABCD);
            else        load_and_start(16'($urandom), 16'($urandom));
            ct = (r == 0) ? 16'h5A5A : 16'($urandom);
            for (int k = 0; k <= dl[r]; k++) begin
                chk("wait_busy", 16'(busy), 16'h1);
                chk("wait_no_err", 16'(err), 16'h0);
                if (r == 1 && k == 1) btn_c = 1'b1;
                if (r == 1 && k == 2) btn_c = 1'b0;
                if (k == dl[r]) begin
                    aes_done = 1'b1;
                    aes_ct = ct;
                end
                @(negedge clkin);
            end
            aes_done = 1'b0;
            aes_ct = 16'($urandom);
            m_ct = ct;
            m_sel = 2;
            chk("show_led", 16'(state_led), 16'h0008);
            chk("show_sel", 16'(disp_sel), 16'(m_sel));
            chk("show_ct", disp_data, m_ct);
            chk("show_not_busy", 16'(busy), 16'h0);
            chk("show_no_err", 16'(err), 16'h0);
            if (r == 0) begin
                for (int i = 0; i < 3; i++) begin
                    release_btn(1'b0, 1'b1);
                    m_sel = (m_sel + 1) % 3;
                    chk("cycle_sel", 16'(disp_sel), 16'(m_sel));
                    chk("cycle_data", disp_data, shown(m_sel));
                end
                aes_done = 1'b1;
                aes_ct = ~m_ct;
                @(negedge clkin);
                aes_done = 1'b0;
                chk("done_in_show_ignored", disp_data, m_ct);
                chk("done_in_show_led", 16'(state_led), 16'h0008);
            end
            if (r == 2) release_btn(1'b1, 1'b1);
            else        release_btn(1'b1, 1'b0);
            m_sel = 0;
            chk("back_led", 16'(state_led), 16'h0001);
            chk("back_sel", 16'(disp_sel), 16'(m_sel));
            chk("back_live_sw", disp_data, sw);
        end

        load_and_start(16'($urandom), 16'($urandom));
        n = 0;
        while (err !== 1'b1 && n < 40) begin
            @(negedge clkin);
            n++;
        end
        chk("timeout_cycles", 16'(n), 16'd8);
        chk("err_led", 16'(state_led), 16'h000F);
        chk("err_not_busy", 16'(busy), 16'h0);
        chk("err_ct_kept", disp_data, m_ct);
        aes_done = 1'b1;
        aes_ct = ~m_ct;
        @(negedge clkin);
        aes_done = 1'b0;
        chk("done_in_err_ignored", disp_data, m_ct);
        release_btn(1'b0, 1'b1);
        chk("err_ignores_up", 16'(err), 16'h1);
        release_btn(1'b1, 1'b0);
        chk("err_exit_led", 16'(state_led), 16'h0001);
        chk("err_exit_err", 16'(err), 16'h0);
        chk("err_exit_sel", 16'(disp_sel), 16'h0);

        load_and_start(16'($urandom), 16'($urandom));
        @(negedge clkin);
        @(posedge clkin);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_led", 16'(state_led), 16'h0001);
        chk("async_busy", 16'(busy), 16'h0);
        chk("async_start", 16'(aes_start), 16'h0);
        chk("async_pt", pt_out, 16'h0);
        chk("async_key", key_out, 16'h0);
        chk("async_sel", 16'(disp_sel), 16'h0);
        chk("async_disp_sw", disp_data, sw);
        @(negedge clkin);
        rstn = 1'b1;
        @(negedge clkin);
        aes_done = 1'b1;
        aes_ct = 16'($urandom);
        @(negedge clkin);
        aes_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_done_led", 16'(state_led), 16'h0001);
            chk("late_done_no_start", 16'(aes_start), 16'h0);
            @(negedge clkin);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_ui_sequencer.md
# aes_ui_sequencer

Button-driven top-level sequencer for the 16-bit AES board build. It takes the debounced centre and up buttons plus the 16 slide switches, and captures plaintext and key from the switches. It launches the AES core, waits for completion with a timeout, and steers the 16-bit display among plaintext, key and ciphertext. It sits between the debounce filters and the AES core / seven-segment driver, and replaces ad-hoc toggle logic as the single owner of core sequencing.

## Interface
Parameters:
- TIMEOUT, 1024, number of clkin cycles allowed in WAIT before error (must be >= 2)

Ports:
- clkin  in  1  system clock; all state changes on rising edge
- rstn  in  1  reset; asynchronous, active-low (one clock; reset is asynchronous and active-low)
- btn_c  in  1  debounced centre button, level
- btn_u  in  1  debounced up button, level
- sw  in  16  slide switches
- aes_done  in  1  one-cycle completion pulse from AES core
- aes_ct  in  16  ciphertext from core, valid in the aes_done cycle
- aes_start  out  1  one-cycle launch pulse to core
- pt_out  out  16  captured plaintext to core
- key_out  out  16  captured key to core
- disp_data  out  16  value for seven-segment driver
- disp_sel  out  2  0=PT, 1=KEY, 2=CT (3 unused)
- state_led  out  4  one-hot phase indication
- busy  out  1  high in START and WAIT
- err  out  1  high in ERR

## Operation
- Button events are releases, detected as falling edges: btn_x_q <= btn_x each cycle, and rel_x = btn_x_q & ~btn_x. Press alone does nothing.
- States and transitions:
  - LD_PT: rel_c -> pt_out<=sw, go to LD_KEY.
  - LD_KEY: rel_c -> key_out<=sw, go to START.
  - START: aes_start=1 for exactly this one cycle; unconditionally go to WAIT and clear the counter.
  - WAIT: counter increments each cycle.
    - aes_done -> ct_reg<=aes_ct, go to SHOW, disp_sel<=2.
    - Otherwise, counter==TIMEOUT-1 -> go to ERR.
  - SHOW: rel_u -> disp_sel cycles 2->0->1->2. rel_c -> go to LD_PT, disp_sel<=0.
  - ERR: rel_c -> go to LD_PT, disp_sel<=0. ct_reg is unchanged.
- disp_data shows:
  - LD_PT: live sw.
  - LD_KEY: live sw.
  - START, WAIT, ERR: ct_reg.
  - SHOW: the register selected by disp_sel.
- state_led encoding: LD_PT=0001, LD_KEY=0010, START/WAIT=0100, SHOW=1000, ERR=1111.
- Boundary rules:
  - rel_c and rel_u in the same cycle: rel_c wins and rel_u is dropped.
  - aes_done in the same cycle as the timeout: done wins (go to SHOW).
  - aes_done outside WAIT is ignored.
  - Buttons are ignored in START and WAIT.
  - Counter width is $clog2(TIMEOUT); it saturates and never wraps inside WAIT.

## Timing
- Reset values:
  - State LD_PT.
  - pt_out, key_out, ct_reg = 0.
  - aes_start = 0, disp_sel = 0, busy = 0, err = 0, state_led = 0001.
  - btn_c_q and btn_u_q = 0, so a button held through reset produces no event.
- Release-to-action latency: the capture or state change happens at the first rising edge where btn_x==0 and btn_x_q==1, i.e. the cycle after the input falls as seen by the register.
- aes_start asserts the cycle after the LD_KEY release edge and lasts one cycle. key_out is stable from that edge onward.
- The earliest accepted aes_done is the cycle after START, i.e. WAIT cycle 0.
- Timeout: with no done, ERR is entered exactly TIMEOUT cycles after entering WAIT.
- rstn asserted mid-WAIT: immediate return to reset values, and aes_start is never re-issued. A late aes_done after reset is ignored.
- All outputs are registered except disp_data, which is a mux of registers and sw.

## Structure
- Shared package aes_ui_pkg holds:
  - State enum (LD_PT, LD_KEY, START, WAIT, SHOW, ERR).
  - disp_sel constants DSEL_PT/DSEL_KEY/DSEL_CT.
  - state_led encodings.
- Sub-module release_detect (inputs clkin, rstn, in; output rel) holds the falling-edge detector. It is instantiated twice.

## Test plan
- Normal run:
  - Stimulus: sw=16'h1234, release btn_c; sw=16'hABCD, release btn_c; core returns aes_done with aes_ct=16'h5A5A three cycles after aes_start.
  - Required response: pt_out=1234, key_out=ABCD, aes_start is a single-cycle pulse, then SHOW with disp_data=5A5A and disp_sel=2.
- Display cycling:
  - Stimulus: in SHOW, release btn_u three times.
  - Required response: disp_data goes 1234, ABCD, 5A5A; disp_sel goes 0, 1, 2.
- Timeout with TIMEOUT=8:
  - Stimulus: aes_done never asserted.
  - Required response: err=1 exactly 8 cycles after entering WAIT; state_led=1111; btn_c release returns to LD_PT.
- Done and timeout in the same cycle:
  - Stimulus: aes_done asserted on WAIT cycle 7 with TIMEOUT=8.
  - Required response: SHOW is entered, err stays 0, ct_reg is captured.
- Simultaneous releases:
  - Stimulus: btn_c and btn_u released in the same cycle in SHOW.
  - Required response: go to LD_PT, disp_sel=0.
- Async reset mid-WAIT:
  - Stimulus: assert rstn=0 between clock edges while in WAIT, then apply a later aes_done pulse.
  - Required response: outputs go to reset values immediately, with no clock needed; the later aes_done causes no state change.
